// File: rtl/data_mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu_pkg
//  Purpose  : Shared encodings for the data-memory load/store unit: access
//             sizes, FSM state codes, lane-select width and the alignment
//             fault rule.
//  Revision : 1.0  initial release
// ============================================================================
package data_mem_lsu_pkg;

    // Byte-lane select width inside a 32-bit word
    localparam int LANE_BITS = 2;

    // Access size encodings as presented on req_size
    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // FSM state codes
    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t ST_IDLE   = 2'd0;
    localparam lsu_state_t ST_ACCESS = 2'd1;
    localparam lsu_state_t ST_WRITE  = 2'd2;
    localparam lsu_state_t ST_RESP   = 2'd3;

    // An access faults on an illegal size or when it does not sit on its
    // natural alignment inside the word.
    function automatic logic lsu_is_fault(
        input logic [1:0]           size,
        input logic [LANE_BITS-1:0] offset
    );
        logic fault;
        fault = 1'b0;
        case (size)
            SZ_HALF:    fault = offset[0];
            SZ_WORD:    fault = (offset != 2'b00);
            SZ_ILLEGAL: fault = 1'b1;
            default:    fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Big-endian lane steering for the load/store unit. Extracts and
//             extends the addressed byte/halfword for loads, merges store
//             data into the fetched word for read-modify-write, and flags
//             misaligned / illegal accesses. Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import data_mem_lsu_pkg::*;
(
    input  logic [31:0]          i_word,
    input  logic [LANE_BITS-1:0] i_offset,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_load_data,
    output logic [31:0]          o_merged,
    output logic                 o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_sign;
    logic        w_half_sign;

    // Lane extraction: offset 0 is the most significant byte (big-endian)
    always_comb begin
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half      = i_offset[1] ? i_word[15:0] : i_word[31:16];
        w_byte_sign = ~i_unsigned & w_byte[7];
        w_half_sign = ~i_unsigned & w_half[15];
    end

    // Load result: sign- or zero-extended lane, or the whole word
    always_comb begin
        o_load_data = i_word;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{w_byte_sign}}, w_byte};
            SZ_HALF: o_load_data = {{16{w_half_sign}}, w_half};
            default: o_load_data = i_word;
        endcase
    end

    // Store merge: replace only the addressed lane, upper store bits ignored
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_offset)
                    2'd0:    o_merged = {i_wdata[7:0], i_word[23:0]};
                    2'd1:    o_merged = {i_word[31:24], i_wdata[7:0], i_word[15:0]};
                    2'd2:    o_merged = {i_word[31:16], i_wdata[7:0], i_word[7:0]};
                    default: o_merged = {i_word[31:8], i_wdata[7:0]};
                endcase
            end
            SZ_HALF: begin
                if (i_offset[1]) begin
                    o_merged = {i_word[31:16], i_wdata[15:0]};
                end else begin
                    o_merged = {i_wdata[15:0], i_word[15:0]};
                end
            end
            SZ_WORD: o_merged = i_wdata;
            default: o_merged = i_word;
        endcase
    end

    // Alignment / size fault
    always_comb begin
        o_fault = lsu_is_fault(i_size, i_offset);
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu
//  Purpose  : Load/store unit driving a word-wide data memory (async read,
//             single synchronous write port). Byte/half/word accesses on a
//             valid/ready handshake, big-endian lanes, read-modify-write for
//             sub-word stores, one-cycle response pulse.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_lsu
    import data_mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    output logic [31:0]         resp_rdata,
    output logic                resp_fault,
    output logic [ADDR_W-1:0]   mem_r_address,
    input  logic [31:0]         mem_r_data,
    output logic [ADDR_W-1:0]   mem_w_address,
    output logic [31:0]         mem_w_data,
    output logic                mem_w_enable
);

    lsu_state_t         r_state;
    logic               r_write;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [ADDR_W+1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_merge;
    logic               r_resp_valid;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_fault;

    logic [31:0]        w_load_data;
    logic [31:0]        w_merged;
    logic               w_fault;
    logic               w_word_store;

    // Lane steering operates on the latched request and live memory data
    lsu_lane_align u_lane_align (
        .i_word      (mem_r_data),
        .i_offset    (r_addr[LANE_BITS-1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged),
        .o_fault     (w_fault)
    );

    // Word stores commit directly from ACCESS; sub-word stores go via WRITE
    always_comb begin
        w_word_store = r_write && (r_size == SZ_WORD) && !w_fault;
    end

    // Request FSM and latched request / response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_merge      <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_fault) begin
                        r_resp_rdata <= 32'h0;
                        r_resp_fault <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (!r_write) begin
                        r_resp_rdata <= w_load_data;
                        r_resp_fault <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (r_size == SZ_WORD) begin
                        r_resp_rdata <= 32'h0;
                        r_resp_fault <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_merge      <= w_merged;
                        r_resp_rdata <= 32'h0;
                        r_resp_fault <= 1'b0;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and memory-port outputs; reset masks ready and the write strobe
    always_comb begin
        req_ready     = (r_state == ST_IDLE) && !rst;
        mem_r_address = r_addr[ADDR_W+1:LANE_BITS];
        mem_w_address = r_addr[ADDR_W+1:LANE_BITS];
        mem_w_data    = (r_state == ST_WRITE) ? r_merge : r_wdata;
        mem_w_enable  = !rst && (((r_state == ST_ACCESS) && w_word_store) ||
                                 (r_state == ST_WRITE));
        resp_valid    = r_resp_valid;
        resp_rdata    = r_resp_rdata;
        resp_fault    = r_resp_fault;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_lsu
//  Purpose  : Self-checking bench for data_mem_lsu with a behavioural memory
//             and an arithmetic reference model of big-endian accesses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;

    localparam int ADDR_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [ADDR_W+1:0]  req_addr;
    logic [31:0]        req_wdata;
    logic               resp_valid;
    logic [31:0]        resp_rdata;
    logic               resp_fault;
    logic [ADDR_W-1:0]  mem_r_address;
    logic [31:0]        mem_r_data;
    logic [ADDR_W-1:0]  mem_w_address;
    logic [31:0]        mem_w_data;
    logic               mem_w_enable;

    logic [31:0]        mem     [0:255];
    logic [31:0]        ref_mem [0:255];
    int                 w_count = 0;
    logic [7:0]         w_last_addr = 8'h0;
    logic [31:0]        w_last_data = 32'h0;
    logic               pre_we = 1'b0;
    logic [7:0]         pre_addr = 8'h0;
    logic [31:0]        pre_data = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_fault    (resp_fault),
        .mem_r_address (mem_r_address),
        .mem_r_data    (mem_r_data),
        .mem_w_address (mem_w_address),
        .mem_w_data    (mem_w_data),
        .mem_w_enable  (mem_w_enable)
    );

    // Behavioural data memory: async read, one synchronous write port
    assign mem_r_data = mem[mem_r_address];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_w_enable) begin
            mem[mem_w_address] <= mem_w_data;
            w_count            <= w_count + 1;
            w_last_addr        <= mem_w_address;
            w_last_data        <= mem_w_data;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off,
                                             input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * (3 - off))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (w >> (8 * (2 - off))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input int off,
                                              input int sz, input logic [31:0] wd);
        logic [31:0] m;
        int          sh;
        if (sz == 2) return wd;
        if (sz == 0) begin
            sh = 8 * (3 - off);
            m  = 32'hFF << sh;
            return (w & ~m) | ((wd & 32'hFF) << sh);
        end
        sh = 8 * (2 - off);
        m  = 32'hFFFF << sh;
        return (w & ~m) | ((wd & 32'hFFFF) << sh);
    endfunction

    function automatic bit ref_fault(input int off, input int sz);
        return (sz == 3) || (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
    endfunction

    // ---------------- drivers ----------------
    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [ADDR_W+1:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
    endtask

    // Issues one request, returns cycles from accept to resp_valid (10 = timeout)
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [ADDR_W+1:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rdata,
                           output logic fault, output int writes);
        int w0;
        int guard;
        drive_req(wr, sz, uns, addr, wd);
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        w0 = w_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        rdata  = resp_rdata;
        fault  = resp_fault;
        writes = w_count - w0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (mem_w_enable !== 1'b0) $display("FAIL reset_wen: got %b want 0", mem_w_enable); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else n_pass++;
        n_checks++; if (resp_fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", resp_fault); else n_pass++;
        n_checks++; if (mem_r_address !== 8'h0) $display("FAIL reset_raddr: got %h want 0", mem_r_address); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", req_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_word_store();
        int lat; logic [31:0] rd; logic f; int wr;
        run_req(1'b1, 2'b10, 1'b0, 10'h014, 32'hDEADBEEF, lat, rd, f, wr);
        ref_mem[5] = 32'hDEADBEEF;
        n_checks++; if (lat != 2) $display("FAIL sw_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (f !== 1'b0) $display("FAIL sw_fault: got %b want 0", f); else n_pass++;
        n_checks++; if (wr != 1) $display("FAIL sw_writes: got %0d want 1", wr); else n_pass++;
        n_checks++; if (w_last_addr !== 8'd5) $display("FAIL sw_waddr: got %h want 05", w_last_addr); else n_pass++;
        n_checks++; if (w_last_data !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", w_last_data); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL sw_pulse_width: got %b want 0", resp_valid); else n_pass++;
    endtask

    task automatic test_byte_loads();
        int lat; logic [31:0] rd; logic f; int wr;
        preload(8'd5, 32'h1180FF44);
        run_req(1'b0, 2'b00, 1'b0, 10'h015, 32'h0, lat, rd, f, wr);
        n_checks++; if (rd !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", rd); else n_pass++;
        n_checks++; if (lat != 2) $display("FAIL lb_latency: got %0d want 2", lat); else n_pass++;
        n_checks++; if (wr != 0) $display("FAIL lb_writes: got %0d want 0", wr); else n_pass++;
        @(posedge clk); #1;
        run_req(1'b0, 2'b00, 1'b1, 10'h015, 32'h0, lat, rd, f, wr);
        n_checks++; if (rd !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", rd); else n_pass++;
        @(posedge clk); #1;
        run_req(1'b0, 2'b01, 1'b0, 10'h016, 32'h0, lat, rd, f, wr);
        n_checks++; if (rd !== 32'hFFFFFF44) $display("FAIL lh: got %h want ffffff44", rd); else n_pass++;
        n_checks++; if (f !== 1'b0) $display("FAIL lh_fault: got %b want 0", f); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_subword_stores();
        int lat; logic [31:0] rd; logic f; int wr;
        preload(8'd5, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 10'h017, 32'h123456AA, lat, rd, f, wr);
        n_checks++; if (lat != 3) $display("FAIL sb_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if (wr != 1) $display("FAIL sb_writes: got %0d want 1", wr); else n_pass++;
        n_checks++; if (mem[5] !== 32'h112233AA) $display("FAIL sb_word: got %h want 112233aa", mem[5]); else n_pass++;
        n_checks++; if (rd !== 32'h0 || f !== 1'b0) $display("FAIL sb_resp: got %h/%b want 0/0", rd, f); else n_pass++;
        @(posedge clk); #1;
        preload(8'd5, 32'h11223344);
        run_req(1'b1, 2'b01, 1'b0, 10'h014, 32'h00005678, lat, rd, f, wr);
        n_checks++; if (mem[5] !== 32'h56783344) $display("FAIL sh_word: got %h want 56783344", mem[5]); else n_pass++;
        n_checks++; if (wr != 1) $display("FAIL sh_writes: got %0d want 1", wr); else n_pass++;
        n_checks++; if (lat != 3) $display("FAIL sh_latency: got %0d want 3", lat); else n_pass++;
        ref_mem[5] = 32'h56783344;
        @(posedge clk); #1;
    endtask

    task automatic test_faults();
        int lat; logic [31:0] rd; logic f; int wr;
        logic [1:0]  szs   [3];
        logic        wrs   [3];
        logic [9:0]  addrs [3];
        szs[0] = 2'b01; wrs[0] = 1'b0; addrs[0] = 10'h013;
        szs[1] = 2'b10; wrs[1] = 1'b1; addrs[1] = 10'h016;
        szs[2] = 2'b11; wrs[2] = 1'b0; addrs[2] = 10'h014;
        for (int i = 0; i < 3; i++) begin
            run_req(wrs[i], szs[i], 1'b0, addrs[i], 32'hCAFEF00D, lat, rd, f, wr);
            n_checks++; if (f !== 1'b1) $display("FAIL fault_flag[%0d]: got %b want 1", i, f); else n_pass++;
            n_checks++; if (rd !== 32'h0) $display("FAIL fault_rdata[%0d]: got %h want 0", i, rd); else n_pass++;
            n_checks++; if (wr != 0) $display("FAIL fault_writes[%0d]: got %0d want 0", i, wr); else n_pass++;
            n_checks++; if (lat != 2) $display("FAIL fault_latency[%0d]: got %0d want 2", i, lat); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        int  w0;
        bit  saw_resp;
        preload(8'd5, 32'h11223344);
        drive_req(1'b1, 2'b00, 1'b0, 10'h017, 32'h123456AA);
        w0 = w_count;
        @(posedge clk); #1;           // ACCESS
        req_valid = 1'b0;
        @(posedge clk); #1;           // WRITE
        n_checks++; if (mem_w_enable !== 1'b1) $display("FAIL rmo_in_write: got %b want 1", mem_w_enable); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_w_enable !== 1'b0) $display("FAIL rmo_wen_gated: got %b want 0", mem_w_enable); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rmo_ready_gated: got %b want 0", req_ready); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rmo_ready_after: got %b want 1", req_ready); else n_pass++;
        saw_resp = resp_valid;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        n_checks++; if (saw_resp) $display("FAIL rmo_no_resp: got 1 want 0"); else n_pass++;
        n_checks++; if (w_count != w0) $display("FAIL rmo_no_write: got %0d want 0", w_count - w0); else n_pass++;
        n_checks++; if (mem[5] !== 32'h11223344) $display("FAIL rmo_mem: got %h want 11223344", mem[5]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp1, exp2;
        preload(8'd7, 32'h9ABC1234);
        preload(8'd8, 32'h0F0F8765);
        exp1 = ref_load(ref_mem[7], 0, 0, 1'b0);
        exp2 = ref_load(ref_mem[8], 2, 1, 1'b1);
        drive_req(1'b0, 2'b00, 1'b0, 10'h01C, 32'h0);
        @(posedge clk); #1;           // first accepted, ACCESS
        drive_req(1'b0, 2'b01, 1'b1, 10'h022, 32'h0);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_access: got %b want 0", req_ready); else n_pass++;
        @(posedge clk); #1;           // RESP of first
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL b2b_resp1_valid: got %b want 1", resp_valid); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_resp: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (resp_rdata !== exp1) $display("FAIL b2b_rdata1: got %h want %h", resp_rdata, exp1); else n_pass++;
        @(posedge clk); #1;           // IDLE, second accepted at next edge
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_idle: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL b2b_pulse: got %b want 0", resp_valid); else n_pass++;
        @(posedge clk); #1;           // ACCESS of second
        req_valid = 1'b0;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_access2: got %b want 0", req_ready); else n_pass++;
        @(posedge clk); #1;           // RESP of second
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL b2b_resp2_valid: got %b want 1", resp_valid); else n_pass++;
        n_checks++; if (resp_rdata !== exp2) $display("FAIL b2b_rdata2: got %h want %h", resp_rdata, exp2); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic f; int wr;
        logic        rw;
        logic [1:0]  sz;
        logic        uns;
        logic [7:0]  wi;
        logic [1:0]  off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          exp_wr;
        bit          exp_f;
        for (int a = 0; a < 256; a++) preload(8'(a), $urandom);
        for (int i = 0; i < 80; i++) begin
            rw  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            wi  = 8'($urandom_range(0, 255));
            off = 2'($urandom_range(0, 3));
            wd  = $urandom;
            exp_f   = ref_fault(int'(off), int'(sz));
            exp_rd  = 32'h0;
            exp_wr  = 0;
            exp_lat = 2;
            if (!exp_f) begin
                if (!rw) begin
                    exp_rd = ref_load(ref_mem[wi], int'(off), int'(sz), uns);
                end else begin
                    ref_mem[wi] = ref_store(ref_mem[wi], int'(off), int'(sz), wd);
                    exp_wr  = 1;
                    exp_lat = (sz == 2'b10) ? 2 : 3;
                end
            end
            run_req(rw, sz, uns, {wi, off}, wd, lat, rd, f, wr);
            n_checks++;
            if (rd !== exp_rd || f !== exp_f || wr != exp_wr || lat != exp_lat)
                $display("FAIL rand[%0d] w=%b sz=%0d u=%b a=%h: got rd=%h f=%b wr=%0d lat=%0d want rd=%h f=%b wr=%0d lat=%0d",
                         i, rw, sz, uns, {wi, off}, rd, f, wr, lat, exp_rd, exp_f, exp_wr, exp_lat);
            else n_pass++;
            n_checks++;
            if (mem[wi] !== ref_mem[wi])
                $display("FAIL rand_mem[%0d] word %h: got %h want %h", i, wi, mem[wi], ref_mem[wi]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_loads();
        test_subword_stores();
        test_faults();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store unit that acts as the initiator toward the word-wide data memory (8-bit word address, asynchronous read, synchronous single write port). It accepts byte, halfword and word loads and stores from the CPU datapath on a valid/ready handshake. Sub-word stores are done as read-modify-write. Byte lanes are big-endian (MIPS), and loads return sign- or zero-extended data with a one-cycle response pulse.

Parameters:
ADDR_W, 8, word-address width of the data memory; byte address is ADDR_W+2 bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends (ignored for stores/word)
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, right-justified for sub-word
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result (0 for stores and faults)
resp_fault  out  1  misaligned or illegal size; valid with resp_valid
mem_r_address  out  ADDR_W  memory read word address
mem_r_data  in  32  memory combinational read data
mem_w_address  out  ADDR_W  memory write word address
mem_w_data  out  32  memory write data
mem_w_enable  out  1  memory write strobe

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_fault 0, all latched request registers 0.
- Reset gating: req_ready=0 and mem_w_enable=0 whenever rst=1, including the reset cycle itself.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/size/unsigned/addr/wdata and go to ACCESS.
- ACCESS, fault check:
  - Fault = size 11, or half with addr[0]=1, or word with addr[1:0]!=0.
  - On fault: no memory write, resp_rdata=0, resp_fault=1, go to RESP.
- ACCESS, load:
  - mem_r_address = addr[ADDR_W+1:2].
  - Byte offset 0 selects bits 31:24; offset 3 selects bits 7:0. Half offset 0 selects 31:16.
  - Sign/zero-extend per req_unsigned, register into resp_rdata, go to RESP.
- ACCESS, word store: mem_w_enable=1, mem_w_data=wdata, go to RESP.
- ACCESS, sub-word store: capture mem_r_data into the merge register with the addressed lane replaced by wdata[7:0] or wdata[15:0], go to WRITE.
- WRITE: mem_w_enable=1, mem_w_data=merge register, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - No response backpressure; the consumer must take the pulse.
- Outputs outside active states:
  - mem_w_address = mem_r_address = latched word address in all states.
  - mem_w_enable=0 outside ACCESS (word store) and WRITE.
- Latency from the accept edge to resp_valid:
  - Load, word store and fault: 2 cycles.
  - Sub-word store: 3 cycles.
- req_ready=0 in ACCESS, WRITE and RESP; the next request can be accepted in the cycle after RESP.
- Writes per store: exactly one memory write per successful store; none per load or fault.
- Reset mid-operation: the request is abandoned, no write and no resp_valid are issued, and the unit returns to IDLE.
- Width rules:
  - req_addr[1:0] selects the lane; upper bits form the word address and are never wrapped or truncated beyond ADDR_W.
  - Store data bits above the size are ignored.

Decomposition:
- Shared package holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum (IDLE/ACCESS/WRITE/RESP);
  - the LANE_BITS=2 constant.
- One combinational sub-module, lsu_lane_align, is natural. Inputs: word, offset, size, unsigned, wdata. Outputs: extracted load value, merged store word, fault flag.
- The FSM and registers stay in data_mem_lsu.

Test Plan:
1. Word store: SW addr 0x14, wdata 0xDEADBEEF → one-cycle mem_w_enable with w_address 5 and w_data 0xDEADBEEF; resp_valid 2 cycles after accept, resp_fault 0.
2. Byte loads: word 5 = 0x1180FF44, LB addr 0x15 → resp_rdata 0xFFFFFF80; LBU addr 0x15 → 0x00000080; LH addr 0x16 → 0xFFFFFF44.
3. Sub-word stores:
   - Word 5 = 0x11223344: SB addr 0x17, wdata 0x123456AA → single write 0x112233AA in the WRITE cycle; resp_valid 3 cycles after accept.
   - Word 5 = 0x11223344: SH addr 0x14, wdata 0x5678 → single write 0x56783344.
4. Faults: LH addr 0x13, SW addr 0x16, size 11 → resp_fault 1, resp_rdata 0, mem_w_enable never asserted.
5. Reset mid-operation: rst asserted while in WRITE for an SB → no mem_w_enable that cycle, memory unchanged, no resp_valid, req_ready=1 the cycle after rst drops.
6. Back-to-back: req_valid held high with two loads → req_ready low through ACCESS/RESP, second request accepted the cycle after the first resp_valid, both results correct.
